ep_bulk_out: RTL

- Bulk OUT end-point: receives DATA0/DATA1 packets from the USB/ULPI packet decoder and buffers them in a packet FIFO.
- Only complete, CRC-good, correctly-sequenced packets are committed and forwarded to the bulk data sink (AXI4-Stream).
- Decides the ACK/NAK handshake and tracks the data-toggle bit; is the host-to-device counterpart of the bulk IN end-point.

---
 rtl/ep_bulk_out_pkg.sv | 26 ++
 rtl/ep_bulk_out_packet_fifo.sv | 94 +++++++++
 rtl/ep_bulk_out.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ep_bulk_out_pkg.sv
// Shared definitions for the bulk OUT end-point: receive FSM state
// encodings, handshake PID values and the high-speed max-packet size.
package ep_bulk_out_pkg;

    typedef enum logic [2:0] {
        RX_HALT = 3'd0,
        RX_IDLE = 3'd1,
        RX_RECV = 3'd2,
        RX_DROP = 3'd3,
        RX_RESP = 3'd4
    } rx_state_t;

    // Handshake PIDs; PID_NONE means "no handshake this cycle".
    localparam logic [3:0] PID_NONE = 4'b0000;
    localparam logic [3:0] PID_ACK  = 4'b0010;
    localparam logic [3:0] PID_NAK  = 4'b1010;
    localparam logic [3:0] PID_NYET = 4'b0110;

    localparam int HS_MAX_PACKET = 512;

    // True when at least 'need' bytes of FIFO space are free.
    function automatic logic room_for(input logic [31:0] free, input logic [31:0] need);
        return (free >= need);
    endfunction

endpackage

// File: rtl/ep_bulk_out_packet_fifo.sv
// Packet FIFO: bytes are written speculatively and only become visible to
// the read side once the packet is saved; drop rewinds the write pointer
// to the last committed position. With STORE_LASTS the final byte of each
// saved packet is flagged so the sink sees a last marker.
module packet_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 2048,
    parameter bit STORE_LASTS = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       save_i,
    input  logic                       drop_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       last_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] lasts_r;
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      commit_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_data_r;
    logic             pop_s;
    logic [AW:0]      prev_wr_s;

    // Only committed bytes may be popped into the output register.
    assign pop_s     = (commit_ptr_r != rd_ptr_r) && (!out_valid_r || ready_i);
    assign prev_wr_s = wr_ptr_r - PTR_ONE;

    // Payload storage, written at the speculative write pointer.
    always_ff @(posedge clock) begin
        if (valid_i) begin
            mem[wr_ptr_r[AW-1:0]] <= data_i;
        end
    end

    // Packet-end flags: cleared on write, set on the final byte at save.
    always_ff @(posedge clock) begin
        if (valid_i) begin
            lasts_r[wr_ptr_r[AW-1:0]] <= 1'b0;
        end
        if (STORE_LASTS && save_i && (wr_ptr_r != commit_ptr_r)) begin
            lasts_r[prev_wr_s[AW-1:0]] <= 1'b1;
        end
    end

    // Pointers, commit/rewind and the registered read stage.
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            wr_ptr_r     <= {(AW+1){1'b0}};
            commit_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
        end else begin
            if (drop_i) begin
                wr_ptr_r <= commit_ptr_r;
            end else if (valid_i) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (save_i) begin
                commit_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                out_valid_r <= 1'b1;
                out_data_r  <= mem[rd_ptr_r[AW-1:0]];
                out_last_r  <= lasts_r[rd_ptr_r[AW-1:0]];
            end else if (ready_i) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign valid_o = out_valid_r;
    assign data_o  = out_data_r;
    assign last_o  = out_last_r;
    // The byte parked in the output register still occupies space.
    assign level_o = wr_ptr_r - rd_ptr_r + {{AW{1'b0}}, out_valid_r};

endmodule

// File: rtl/ep_bulk_out.sv
// Bulk OUT end-point: accepts DATA0/DATA1 payloads into a packet FIFO,
// commits only complete, CRC-good, in-sequence packets to the sink stream
// and decides the ACK/NAK handshake while tracking the data toggle.
// Optional build macro EP_BULK_OUT_PING_EN adds PING handling (ping_i)
// and NYET signalling (nyet_o).
module ep_bulk_out
    import ep_bulk_out_pkg::*;
#(
    parameter int MAX_PACKET_LENGTH = HS_MAX_PACKET,
    parameter int PACKET_FIFO_DEPTH = 2048,
    parameter bit ENABLED           = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_conf_i,
    input  logic       clr_conf_i,
    input  logic       selected_i,
`ifdef EP_BULK_OUT_PING_EN
    input  logic       ping_i,
    output logic       nyet_o,
`endif
    input  logic       rx_parity_i,
    input  logic       rx_crc_ok_i,
    output logic       ack_o,
    output logic       nak_o,
    output logic       ep_ready_o,
    output logic       stalled_o,
    output logic       parity_o,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tkeep,
    input  logic       s_tlast,
    input  logic [7:0] s_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic [7:0] m_tdata
);

    localparam int AW = $clog2(PACKET_FIFO_DEPTH);
    localparam int CW = $clog2(MAX_PACKET_LENGTH) + 1;
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PACKET_LENGTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   FIFO_SIZE = (AW+1)'(PACKET_FIFO_DEPTH);

    rx_state_t   state_r, state_s;
    logic        configured_r, configured_s;
    logic        parity_r, parity_s;
    logic        nak_pending_r, nak_pending_s;
    logic [CW-1:0] count_r, count_s;
    logic [3:0]  hs_pid_r, hs_pid_s;
    logic        save_r, save_s;
    logic        drop_r, drop_s;
    logic        ep_ready_r;
    logic [AW:0] level_s;
    logic [AW:0] free_s;
    logic        fifo_clear_s;
    logic        fifo_wr_s;
    logic        bump_s;
    logic [CW-1:0] count_last_s;

    assign free_s       = FIFO_SIZE - level_s;
    assign fifo_clear_s = set_conf_i || clr_conf_i;
    // The count saturates one past MAX so long babble cannot wrap it; bytes
    // beyond MAX are never written, so the FIFO cannot overflow.
    assign bump_s       = s_tkeep && (count_r <= MAX_CNT);
    assign count_last_s = bump_s ? (count_r + CNT_ONE) : count_r;
    assign fifo_wr_s    = (state_r == RX_RECV) && s_tvalid && s_tkeep &&
                          (count_r < MAX_CNT) && !fifo_clear_s;

    // Configuration flag: clear wins over set; a disabled end-point stays halted.
    always_comb begin
        configured_s = configured_r;
        if (clr_conf_i || !ENABLED) begin
            configured_s = 1'b0;
        end else if (set_conf_i) begin
            configured_s = 1'b1;
        end else begin
            configured_s = configured_r;
        end
    end

    // Receive FSM: next state, verdict, handshake and toggle update.
    always_comb begin
        state_s       = state_r;
        parity_s      = parity_r;
        nak_pending_s = nak_pending_r;
        count_s       = count_r;
        hs_pid_s      = PID_NONE;
        save_s        = 1'b0;
        drop_s        = 1'b0;
        if (clr_conf_i || !ENABLED) begin
            state_s       = RX_HALT;
            parity_s      = 1'b0;
            nak_pending_s = 1'b0;
            count_s       = {CW{1'b0}};
        end else if (set_conf_i) begin
            state_s       = RX_IDLE;
            parity_s      = 1'b0;
            nak_pending_s = 1'b0;
            count_s       = {CW{1'b0}};
        end else begin
            case (state_r)
                RX_HALT: begin
                    state_s = RX_HALT;
                end
                RX_IDLE: begin
                    if (selected_i) begin
                        count_s = {CW{1'b0}};
                        if (ep_ready_r) begin
                            state_s = RX_RECV;
                        end else begin
                            state_s       = RX_DROP;
                            nak_pending_s = 1'b1;
                        end
`ifdef EP_BULK_OUT_PING_EN
                    end else if (ping_i) begin
                        hs_pid_s = ep_ready_r ? PID_ACK : PID_NAK;
`endif
                    end else begin
                        state_s = RX_IDLE;
                    end
                end
                RX_RECV: begin
                    if (s_tvalid && s_tlast) begin
                        count_s = count_last_s;
                        state_s = RX_RESP;
                        if (!rx_crc_ok_i || (count_last_s > MAX_CNT)) begin
                            // Corrupt or babbling: silence lets the host time out.
                            drop_s = 1'b1;
                        end else if (rx_parity_i != parity_r) begin
                            // Host missed our earlier ACK and resent the packet.
                            drop_s   = 1'b1;
                            hs_pid_s = PID_ACK;
                        end else begin
                            save_s   = 1'b1;
                            parity_s = !parity_r;
`ifdef EP_BULK_OUT_PING_EN
                            hs_pid_s = room_for(32'(free_s), 32'(2 * MAX_PACKET_LENGTH)) ?
                                       PID_ACK : PID_NYET;
`else
                            hs_pid_s = PID_ACK;
`endif
                        end
                    end else if (s_tvalid) begin
                        count_s = count_last_s;
                    end else begin
                        count_s = count_r;
                    end
                end
                RX_DROP: begin
                    if (s_tvalid && s_tlast) begin
                        state_s       = RX_RESP;
                        hs_pid_s      = nak_pending_r ? PID_NAK : PID_NONE;
                        nak_pending_s = 1'b0;
                    end else begin
                        state_s = RX_DROP;
                    end
                end
                RX_RESP: begin
                    state_s = RX_IDLE;
                end
                default: begin
                    state_s = RX_HALT;
                end
            endcase
        end
    end

    // State, toggle, handshake and readiness registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= RX_HALT;
            configured_r  <= 1'b0;
            parity_r      <= 1'b0;
            nak_pending_r <= 1'b0;
            count_r       <= {CW{1'b0}};
            hs_pid_r      <= PID_NONE;
            save_r        <= 1'b0;
            drop_r        <= 1'b0;
            ep_ready_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            configured_r  <= configured_s;
            parity_r      <= parity_s;
            nak_pending_r <= nak_pending_s;
            count_r       <= count_s;
            hs_pid_r      <= hs_pid_s;
            save_r        <= save_s;
            drop_r        <= drop_s;
            // Level is stale during a clear, so hold off one cycle.
            ep_ready_r    <= configured_s && !fifo_clear_s &&
                             room_for(32'(free_s), 32'(MAX_PACKET_LENGTH));
        end
    end

    packet_fifo #(
        .WIDTH       (8),
        .DEPTH       (PACKET_FIFO_DEPTH),
        .STORE_LASTS (1'b1)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear_i (fifo_clear_s),
        .valid_i (fifo_wr_s),
        .data_i  (s_tdata),
        .save_i  (save_r),
        .drop_i  (drop_r),
        .valid_o (m_tvalid),
        .ready_i (m_tready),
        .last_o  (m_tlast),
        .data_o  (m_tdata),
        .level_o (level_s)
    );

    assign s_tready   = (state_r == RX_RECV) || (state_r == RX_DROP);
    assign ack_o      = (hs_pid_r == PID_ACK);
    assign nak_o      = (hs_pid_r == PID_NAK);
`ifdef EP_BULK_OUT_PING_EN
    assign nyet_o     = (hs_pid_r == PID_NYET);
`endif
    assign ep_ready_o = ep_ready_r;
    assign stalled_o  = !configured_r;
    assign parity_o   = parity_r;

endmodule
